timing_gen: RTL and testbench

Drum timing generator for the G-15 CPU. It divides the fast fabric clock into drum bit times, locks to the drum origin mark, and produces the word-time phase signals consumed directly by the CPU top level (T0, T1, T2, T13, T21, T28, T29, TE, TF, TS), plus a word address for the memory lines. It sits immediately upstream of the CPU, between the drum-origin/bit-strobe source and every CPU gate.

---
 rtl/g15_timing_pkg.sv | 29 ++
 rtl/timing_decode.sv | 32 +++
 rtl/timing_gen.sv | 109 ++++++++++
 tb/tb_timing_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/g15_timing_pkg.sv
// Shared definitions for the G-15 drum timing generator: default geometry,
// FSM states, bit/word index types and the bundle of word-time phase signals.
package g15_timing_pkg;

    localparam int DEFAULT_BITS_PER_WORD  = 29;
    localparam int DEFAULT_WORDS_PER_LINE = 108;

    typedef enum logic {
        SEARCH,
        LOCKED
    } timing_state_t;

    typedef logic [4:0] bit_t;
    typedef logic [6:0] word_t;

    typedef struct packed {
        logic t0;
        logic t1;
        logic t2;
        logic t13;
        logic t21;
        logic t28;
        logic t29;
        logic te;
        logic tf;
        logic ts;
    } phase_t;

endpackage

// File: rtl/timing_decode.sv
// Combinational decode of a bit/word position into the CPU word-time phases.
// The caller registers the result and qualifies it with the lock state.
module timing_decode
    import g15_timing_pkg::*;
#(
    parameter int BITS_PER_WORD  = DEFAULT_BITS_PER_WORD,
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
    input  logic [4:0] bit_num,
    input  logic [6:0] word_num,
    output phase_t     phase
);

    localparam bit_t  LAST_BIT  = bit_t'(BITS_PER_WORD - 1);
    localparam word_t LAST_WORD = word_t'(WORDS_PER_LINE - 1);

    // T29 marks the last bit of the odd word, i.e. the end of a double-word pair
    always_comb begin
        phase     = '0;
        phase.t0  = (bit_num == bit_t'(0));
        phase.t1  = (bit_num == bit_t'(1));
        phase.t2  = (bit_num == bit_t'(2));
        phase.t13 = (bit_num == bit_t'(13));
        phase.t21 = (bit_num == bit_t'(21));
        phase.t28 = (bit_num == LAST_BIT);
        phase.t29 = (bit_num == LAST_BIT) && word_num[0];
        phase.te  = !word_num[0];
        phase.tf  = (word_num == LAST_WORD);
        phase.ts  = (bit_num == bit_t'(1));
    end

endmodule

// File: rtl/timing_gen.sv
// Drum timing generator: counts bit times on BIT_EN, locks to the drum origin
// mark and drives registered word-time phases, word/bit address and sync status.
module timing_gen
    import g15_timing_pkg::*;
#(
    parameter int BITS_PER_WORD  = DEFAULT_BITS_PER_WORD,
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
    input  logic       CLOCK,
    input  logic       rst_n,
    input  logic       BIT_EN,
    input  logic       ORIGIN,
    output logic       T0,
    output logic       T1,
    output logic       T2,
    output logic       T13,
    output logic       T21,
    output logic       T28,
    output logic       T29,
    output logic       TE,
    output logic       TF,
    output logic       TS,
    output logic [6:0] WORD,
    output logic [4:0] BIT,
    output logic       LOCKED,
    output logic       SYNC_ERR
);

    localparam bit_t  LAST_BIT  = bit_t'(BITS_PER_WORD - 1);
    localparam word_t LAST_WORD = word_t'(WORDS_PER_LINE - 1);

    timing_state_t state, state_n;
    bit_t          bit_cnt, bit_n;
    word_t         word_cnt, word_n;
    logic          sync_err, sync_err_n;
    phase_t        phase_d, phase_q;
    logic          at_origin;

    assign at_origin = (bit_cnt == LAST_BIT) && (word_cnt == LAST_WORD);

    // An ORIGIN anywhere but the last bit of the last word resyncs the counters
    // to the mark and latches the error; the normal wrap covers the expected case.
    always_comb begin
        state_n    = state;
        bit_n      = bit_cnt;
        word_n     = word_cnt;
        sync_err_n = sync_err;
        if (BIT_EN) begin
            if (state == g15_timing_pkg::SEARCH) begin
                if (ORIGIN) begin
                    bit_n   = '0;
                    word_n  = '0;
                    state_n = g15_timing_pkg::LOCKED;
                end
            end else if (ORIGIN && !at_origin) begin
                bit_n      = '0;
                word_n     = '0;
                sync_err_n = 1'b1;
            end else if (bit_cnt == LAST_BIT) begin
                bit_n  = '0;
                word_n = (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
            end else begin
                bit_n = bit_cnt + 1'b1;
            end
        end
    end

    timing_decode #(
        .BITS_PER_WORD (BITS_PER_WORD),
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_decode (
        .bit_num (bit_n),
        .word_num(word_n),
        .phase   (phase_d)
    );

    // Phases are decoded from the next-state counts so they move with BIT/WORD
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= g15_timing_pkg::SEARCH;
            bit_cnt  <= '0;
            word_cnt <= '0;
            sync_err <= 1'b0;
            phase_q  <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            word_cnt <= word_n;
            sync_err <= sync_err_n;
            phase_q  <= (state_n == g15_timing_pkg::LOCKED) ? phase_d : '0;
        end
    end

    assign T0       = phase_q.t0;
    assign T1       = phase_q.t1;
    assign T2       = phase_q.t2;
    assign T13      = phase_q.t13;
    assign T21      = phase_q.t21;
    assign T28      = phase_q.t28;
    assign T29      = phase_q.t29;
    assign TE       = phase_q.te;
    assign TF       = phase_q.tf;
    assign TS       = phase_q.ts;
    assign WORD     = word_cnt;
    assign BIT      = bit_cnt;
    assign LOCKED   = (state == g15_timing_pkg::LOCKED);
    assign SYNC_ERR = sync_err;

endmodule

// File: tb/tb_timing_gen.sv
// Self-checking bench for timing_gen: constant vector table, directed drum
// sequences and random strobes against a position-counter reference model.
module tb_timing_gen;

    localparam int BPW        = 29;
    localparam int WPL        = 108;
    localparam int LINE_BITS  = BPW * WPL;

    localparam logic [9:0] P_T0  = 10'b10_0000_0000;
    localparam logic [9:0] P_T1  = 10'b01_0000_0000;
    localparam logic [9:0] P_T2  = 10'b00_1000_0000;
    localparam logic [9:0] P_TE  = 10'b00_0000_0100;
    localparam logic [9:0] P_TS  = 10'b00_0000_0001;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       origin = 1'b0;
    logic       t0, t1, t2, t13, t21, t28, t29, te, tf, ts;
    logic [6:0] word;
    logic [4:0] bit_num;
    logic       locked, sync_err;

    int errors = 0;
    int checks = 0;

    // reference model: absolute position within the drum line
    bit m_locked;
    bit m_err;
    int m_pos;

    typedef struct {
        logic       en;
        logic       org;
        logic [4:0] exp_bit;
        logic [6:0] exp_word;
        logic       exp_locked;
        logic       exp_err;
        logic [9:0] exp_phase;
        string      name;
    } vec_t;

    vec_t tbl[8];

    timing_gen dut (
        .CLOCK   (clock),
        .rst_n   (rst_n),
        .BIT_EN  (bit_en),
        .ORIGIN  (origin),
        .T0      (t0),
        .T1      (t1),
        .T2      (t2),
        .T13     (t13),
        .T21     (t21),
        .T28     (t28),
        .T29     (t29),
        .TE      (te),
        .TF      (tf),
        .TS      (ts),
        .WORD    (word),
        .BIT     (bit_num),
        .LOCKED  (locked),
        .SYNC_ERR(sync_err)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] observed();
        return {locked, sync_err, word, bit_num,
                t0, t1, t2, t13, t21, t28, t29, te, tf, ts};
    endfunction

    function automatic logic [23:0] model_expected();
        int b = m_pos % BPW;
        int w = m_pos / BPW;
        logic [9:0] p = '0;
        if (m_locked)
            p = {b == 0, b == 1, b == 2, b == 13, b == 21, b == BPW - 1,
                 (b == BPW - 1) && (w % 2 == 1), w % 2 == 0, w == WPL - 1, b == 1};
        return {m_locked, m_err, 7'(w), 5'(b), p};
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_pos    = 0;
    endtask

    task automatic model_step(input logic en, input logic org);
        if (!en) return;
        if (!m_locked) begin
            if (org) begin
                m_locked = 1'b1;
                m_pos    = 0;
            end
        end else if (org && m_pos != LINE_BITS - 1) begin
            m_err = 1'b1;
            m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % LINE_BITS;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic org);
        bit_en = en;
        origin = org;
        @(posedge clock);
        model_step(en, org);
        #1;
        bit_en = 1'b0;
        origin = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        logic [23:0] exp_v = model_expected();
        logic [23:0] act_v = observed();
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (model word=%0d bit=%0d)",
                     name, act_v, exp_v, m_pos / BPW, m_pos % BPW);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic runTo(input int target, input string name);
        int guard = 0;
        while (m_pos != target && guard < 2 * LINE_BITS) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput(name);
            guard++;
        end
        if (m_pos != target) begin
            errors++;
            checks++;
            $display("[TB] FAIL %s: position %0d not reached, at %0d", name, target, m_pos);
        end
    endtask

    task automatic doReset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_reset");
        repeat (2) @(posedge clock);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 5'd0, 7'd0, 1'b0, 1'b0, 10'b0,               "search_strobe"};
        tbl[1] = '{1'b0, 1'b1, 5'd0, 7'd0, 1'b0, 1'b0, 10'b0,               "origin_no_en"};
        tbl[2] = '{1'b1, 1'b1, 5'd0, 7'd0, 1'b1, 1'b0, P_T0 | P_TE,         "lock"};
        tbl[3] = '{1'b1, 1'b0, 5'd1, 7'd0, 1'b1, 1'b0, P_T1 | P_TS | P_TE,  "bit1"};
        tbl[4] = '{1'b0, 1'b1, 5'd1, 7'd0, 1'b1, 1'b0, P_T1 | P_TS | P_TE,  "hold_no_en"};
        tbl[5] = '{1'b1, 1'b0, 5'd2, 7'd0, 1'b1, 1'b0, P_T2 | P_TE,         "bit2"};
        tbl[6] = '{1'b1, 1'b1, 5'd0, 7'd0, 1'b1, 1'b1, P_T0 | P_TE,         "early_origin"};
        tbl[7] = '{1'b1, 1'b0, 5'd1, 7'd0, 1'b1, 1'b1, P_T1 | P_TS | P_TE,  "after_err"};

        model_reset();
        #12;
        checkOutput("reset_state");
        #5 rst_n = 1'b1;
        @(posedge clock);
        #1;

        // no ORIGIN: stays in SEARCH with counters at zero
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("search_hold");
        end

        // constant vector table
        for (int i = 0; i < 8; i++) begin
            logic [23:0] exp_v;
            applyStimulus(tbl[i].en, tbl[i].org);
            exp_v = {tbl[i].exp_locked, tbl[i].exp_err, tbl[i].exp_word,
                     tbl[i].exp_bit, tbl[i].exp_phase};
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("[TB] FAIL tbl_%s: got %h expected %h", tbl[i].name, observed(), exp_v);
            end
        end

        // first word after locking
        doReset();
        applyStimulus(1'b1, 1'b1);
        checkValue("first_t0", int'(t0), 1);
        checkValue("first_te", int'(te), 1);
        checkValue("first_locked", int'(locked), 1);
        applyStimulus(1'b1, 1'b0);
        checkValue("ts_bit1", int'(ts), 1);
        runTo(13, "word0");
        checkValue("t13", int'(t13), 1);
        runTo(28, "word0");
        checkValue("t28", int'(t28), 1);
        checkValue("t29_word0", int'(t29), 0);
        applyStimulus(1'b1, 1'b0);
        checkValue("wrap_bit", int'(bit_num), 0);
        checkValue("wrap_word", int'(word), 1);
        checkValue("word1_te", int'(te), 0);
        runTo(BPW + 28, "word1");
        checkValue("t29_word1", int'(t29), 1);

        // full line with ORIGIN at the expected point
        runTo(107 * BPW, "line");
        checkValue("tf_word107", int'(tf), 1);
        runTo(LINE_BITS - 1, "line");
        checkValue("tf_last_bit", int'(tf), 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("expected_origin");
        checkValue("origin_no_err", int'(sync_err), 0);
        checkValue("origin_tf_clear", int'(tf), 0);
        runTo(28, "word0_again");
        checkValue("t29_word0_again", int'(t29), 0);

        // misplaced ORIGIN resyncs and latches the error
        runTo(40 * BPW + 7, "to_w40");
        applyStimulus(1'b1, 1'b1);
        checkValue("err_set", int'(sync_err), 1);
        checkValue("err_bit", int'(bit_num), 0);
        checkValue("err_word", int'(word), 0);
        checkValue("err_locked", int'(locked), 1);
        runTo(LINE_BITS - 1, "after_err");
        applyStimulus(1'b1, 1'b1);
        checkValue("err_sticky", int'(sync_err), 1);
        checkOutput("good_origin_after_err");

        // asynchronous reset in the middle of word 55
        runTo(55 * BPW + 10, "to_w55");
        doReset();
        @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("post_reset_search");
        end

        // random strobes and occasional ORIGIN marks
        for (int i = 0; i < 8000; i++) begin
            logic en  = 1'($urandom_range(0, 1));
            logic org = 1'b0;
            if (m_locked && m_pos == LINE_BITS - 1)
                org = ($urandom_range(0, 3) != 0);
            else
                org = ($urandom_range(0, 399) == 0);
            applyStimulus(en, org);
            checkOutput("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
